// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Consumer-side handshake bundle of the UART receive controller.
//   master : the receiver (drives data/valid/done/err/overrun, reads ack)
//   slave  : the consumer (reads the frame outputs, drives ack)
//   Signals:
//     data    - last good frame, LSB received first
//     valid   - data holds an unconsumed frame
//     done    - one-cycle pulse, good frame captured
//     err     - one-cycle pulse, framing error (stop bit low)
//     overrun - sticky, a good frame landed while valid was still set
//     ack     - consumer has taken data; clears valid and overrun
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              done;
  logic              err;
  logic              overrun;
  logic              ack;

  modport master (
    output data, valid, done, err, overrun,
    input  ack
  );

  modport slave (
    input  data, valid, done, err, overrun,
    output ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Frame controller for a UART receiver. A start-bit falling edge (fall)
//   arms a bit-period counter that samples the synchronized line (in) at
//   the middle of the start bit, every data bit (LSB first) and the stop
//   bit. Good frames are captured into data/valid with a done pulse; a low
//   stop bit produces an err pulse instead.
//   Ports:
//     clk    - single clock, rising edge
//     nReset - asynchronous, active-low reset
//     in     - synchronized serial line level, idle high
//     fall   - one-cycle falling-edge pulse of in
//     rate   - clock cycles per bit (frames start only when rate >= 2)
//     busy   - high whenever the controller is not idle
//     rx_if  - consumer handshake (data, valid, done, err, overrun, ack)
module uart_rx_ctrl #(
  parameter int DATA_W = 8,
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              in,
  input  logic              fall,
  input  logic [RATE_W-1:0] rate,
  output logic              busy,
  uart_rx_ctrl_if.master    rx_if
);

  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  // Next-state and output logic. The rate is latched at the start edge so
  // a mid-frame change of the rate input cannot disturb the frame. The
  // first count is half a period so every sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rate_d    = rate_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    overrun_d = overrun_q;

    // Consumer acknowledge; a capture in the same cycle overrides below.
    if (rx_if.ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fall && (rate >= RATE_W'(2))) begin
          rate_d  = rate;
          cnt_d   = (rate >> 1) - RATE_W'(1);
          state_d = START;
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - RATE_W'(1);
        end else if (!in) begin
          state_d = DATA;
          cnt_d   = rate_q - RATE_W'(1);
          idx_d   = '0;
        end else begin
          // Line already back high at mid start bit: treat as a glitch.
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - RATE_W'(1);
        end else begin
          shift_d[idx_q] = in;
          cnt_d          = rate_q - RATE_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - RATE_W'(1);
        end else begin
          state_d = IDLE;
          if (in) begin
            data_d    = shift_q;
            done_d    = 1'b1;
            valid_d   = 1'b1;
            // Overrun only when the old frame was not taken this cycle.
            overrun_d = overrun_q | (valid_q & ~rx_if.ack);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any frame silently.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rate_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rate_q    <= rate_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.data    = data_q;
  assign rx_if.valid   = valid_q;
  assign rx_if.done    = done_q;
  assign rx_if.err     = err_q;
  assign rx_if.overrun = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Drives whole serial frames onto the line and compares every cycle
//   against a frame-level reference: expected sample points are computed
//   arithmetically from the bit period, and the captured byte is whatever
//   the generated line waveform holds at those points.
module tb_uart_rx_ctrl;

  localparam int DATA_W = 8;
  localparam int RATE_W = 16;

  logic              clk;
  logic              n_reset;
  logic              line_in;
  logic              fall;
  logic [RATE_W-1:0] rate;
  logic              busy;

  uart_rx_ctrl_if #(.DATA_W(DATA_W)) rx_if ();

  uart_rx_ctrl #(
    .DATA_W (DATA_W),
    .RATE_W (RATE_W)
  ) dut (
    .clk    (clk),
    .nReset (n_reset),
    .in     (line_in),
    .fall   (fall),
    .rate   (rate),
    .busy   (busy),
    .rx_if  (rx_if)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state of the consumer-visible outputs.
  logic [DATA_W-1:0] exp_data;
  bit                exp_valid, exp_done, exp_err, exp_ovr, exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_output("data",    32'(rx_if.data),    32'(exp_data));
    check_output("valid",   32'(rx_if.valid),   32'(exp_valid));
    check_output("done",    32'(rx_if.done),    32'(exp_done));
    check_output("err",     32'(rx_if.err),     32'(exp_err));
    check_output("overrun", 32'(rx_if.overrun), 32'(exp_ovr));
    check_output("busy",    32'(busy),          32'(exp_busy));
  endtask

  task automatic model_reset();
    exp_data  = '0;
    exp_valid = 0;
    exp_done  = 0;
    exp_err   = 0;
    exp_ovr   = 0;
    exp_busy  = 0;
  endtask

  // One clock of consumer-visible behaviour: capture, framing error, ack.
  task automatic model_step(input bit cap, input bit errp, input bit ack_in,
                            input logic [DATA_W-1:0] cap_data, input bit busy_next);
    exp_done = cap;
    exp_err  = errp;
    exp_busy = busy_next;
    if (cap) begin
      if (exp_valid && !ack_in) exp_ovr = 1;
      exp_valid = 1;
      exp_data  = cap_data;
    end else if (ack_in && exp_valid) begin
      exp_valid = 0;
      exp_ovr   = 0;
    end
  endtask

  // Line level k cycles after the start edge for a frame (or a short glitch).
  function automatic bit line_level(int k, logic [DATA_W-1:0] b, bit stop_bit, int r, bit glitch);
    if (glitch) return (k < 3) ? 1'b0 : 1'b1;
    if (k < r) return 1'b0;
    if (k < r * (DATA_W + 1)) return b[(k / r) - 1];
    if (k < r * (DATA_W + 2)) return stop_bit;
    return 1'b1;
  endfunction

  // Sends one frame starting with fall in the first cycle. Optional mid-frame
  // rate change, ack in one cycle, extra ignored fall pulses, or a reset abort.
  task automatic apply_stimulus(input logic [DATA_W-1:0] byte_val, input bit stop_bit, input int r,
                                input bit glitch, input int new_rate, input int chg_k,
                                input int ack_k, input int abort_k, input int n_extra_falls);
    int half, stop_samp, last_busy, len;
    bit start_ok, good;
    logic [DATA_W-1:0] got;
    bit fall_at[];
    half      = r / 2;
    stop_samp = half + (DATA_W + 1) * r;
    start_ok  = !line_level(half, byte_val, stop_bit, r, glitch);
    got       = '0;
    good      = 0;
    if (start_ok) begin
      for (int j = 0; j < DATA_W; j++)
        got[j] = line_level(half + (j + 1) * r, byte_val, stop_bit, r, glitch);
      good      = line_level(stop_samp, byte_val, stop_bit, r, glitch);
      last_busy = stop_samp;
    end else begin
      last_busy = half;
    end
    len     = stop_samp + 3;
    fall_at = new[len];
    if (last_busy >= 3)
      for (int i = 0; i < n_extra_falls; i++)
        fall_at[$urandom_range(last_busy - 1, 2)] = 1;

    for (int k = 0; k < len; k++) begin
      if (k == abort_k) begin
        n_reset   = 0;
        line_in   = 1;
        fall      = 0;
        rx_if.ack = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        n_reset = 1;
        compare_all();
        return;
      end
      line_in   = line_level(k, byte_val, stop_bit, r, glitch);
      fall      = (k == 0) || fall_at[k];
      rate      = (chg_k >= 0 && k >= chg_k) ? RATE_W'(new_rate) : RATE_W'(r);
      rx_if.ack = (k == ack_k);
      model_step(start_ok && good && (k == stop_samp),
                 start_ok && !good && (k == stop_samp),
                 rx_if.ack, got, (k + 1) <= last_busy);
      @(posedge clk);
      #1;
      compare_all();
    end
    line_in   = 1;
    fall      = 0;
    rx_if.ack = 0;
  endtask

  task automatic idle_cycles(input int n, input bit rand_ack);
    for (int i = 0; i < n; i++) begin
      line_in   = 1;
      fall      = 0;
      rx_if.ack = rand_ack ? ($urandom_range(0, 2) == 0) : 1'b0;
      model_step(0, 0, rx_if.ack, '0, 0);
      @(posedge clk);
      #1;
      compare_all();
    end
    rx_if.ack = 0;
  endtask

  task automatic ack_pulse();
    rx_if.ack = 1;
    model_step(0, 0, 1, '0, 0);
    @(posedge clk);
    #1;
    compare_all();
    rx_if.ack = 0;
  endtask

  // Fall pulses with an unusable rate must never start a frame.
  task automatic low_rate_falls(input int n, input int r);
    for (int i = 0; i < n; i++) begin
      rate      = RATE_W'(r);
      fall      = (i % 2 == 0);
      line_in   = !fall;
      rx_if.ack = 0;
      model_step(0, 0, 0, '0, 0);
      @(posedge clk);
      #1;
      compare_all();
    end
    fall    = 0;
    line_in = 1;
  endtask

  initial begin
    int r, nr, chg, ackk;
    n_reset   = 1;
    line_in   = 1;
    fall      = 0;
    rate      = RATE_W'(16);
    rx_if.ack = 0;
    model_reset();
    #2 n_reset = 0;
    #1 compare_all();
    repeat (2) @(posedge clk);
    #1 n_reset = 1;
    compare_all();
    idle_cycles(2, 0);

    $display("[TB] good frame 0xA5 at rate 16");
    apply_stimulus(8'hA5, 1, 16, 0, 16, -1, -1, -1, 0);
    idle_cycles(2, 0);

    $display("[TB] start glitch");
    apply_stimulus(8'h00, 1, 16, 1, 16, -1, -1, -1, 0);
    idle_cycles(2, 0);

    $display("[TB] framing error on 0x3C");
    apply_stimulus(8'h3C, 0, 16, 0, 16, -1, -1, -1, 0);
    idle_cycles(2, 0);
    ack_pulse();
    ack_pulse();

    $display("[TB] overrun with 0x11 then 0x22");
    apply_stimulus(8'h11, 1, 16, 0, 16, -1, -1, -1, 0);
    idle_cycles(3, 0);
    apply_stimulus(8'h22, 1, 16, 0, 16, -1, -1, -1, 0);
    idle_cycles(2, 0);
    ack_pulse();
    idle_cycles(1, 0);

    $display("[TB] reset during bit 4, then 0x5A");
    apply_stimulus(8'h77, 1, 16, 0, 16, -1, -1, 16 * 5 + 4, 0);
    idle_cycles(2, 0);
    apply_stimulus(8'h5A, 1, 16, 0, 16, -1, -1, -1, 0);
    idle_cycles(2, 0);

    $display("[TB] rate below 2 and mid-frame rate change");
    low_rate_falls(12, 1);
    low_rate_falls(6, 0);
    apply_stimulus(8'h96, 1, 16, 0, 8, 40, -1, -1, 0);
    idle_cycles(2, 0);

    $display("[TB] capture and ack in the same cycle");
    apply_stimulus(8'hC3, 1, 16, 0, 16, -1, 8 + 9 * 16, -1, 0);
    idle_cycles(2, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 10; f++) begin
      r    = $urandom_range(2, 24);
      nr   = $urandom_range(1, 30);
      chg  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, r * (DATA_W + 1)) : -1;
      ackk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r * (DATA_W + 2)) : -1;
      apply_stimulus(DATA_W'($urandom), $urandom_range(0, 4) != 0, r, 0, nr, chg, ackk, -1, 2);
      idle_cycles($urandom_range(1, 5), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame.
REQ-002 SHALL have parameter RATE_W, default 16: width of the bit-period divisor.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in  input  1  synchronized serial line level (idle high).
REQ-006 SHALL have port fall  input  1  one-cycle falling-edge pulse of in, from the Rx edge synchronizer.
REQ-007 SHALL have port rate  input  RATE_W  clock cycles per bit.
REQ-008 SHALL have port ack  input  1  consumer has taken data; clears valid.
REQ-009 SHALL have port data  output  DATA_W  last good frame, LSB received first.
REQ-010 SHALL have port valid  output  1  data holds an unconsumed frame.
REQ-011 SHALL have port done  output  1  one-cycle pulse: good frame captured.
REQ-012 SHALL have port err  output  1  one-cycle pulse: framing error (stop bit low).
REQ-013 SHALL have port overrun  output  1  sticky: a good frame was captured while valid was still set.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, START, DATA, STOP; all outputs registered.
REQ-016 In IDLE with fall=1 and rate>=2, SHALL latch rate, load cnt=(rate>>1)-1, go to START next cycle.
REQ-017 In IDLE with rate<2, SHALL ignore fall and remain IDLE.
REQ-018 SHALL ignore fall in any state other than IDLE.
REQ-019 In START/DATA/STOP, SHALL decrement cnt each cycle while cnt!=0 and act only on the cycle cnt==0 (the sample cycle).
REQ-020 START sample: in=0 -> DATA, cnt=latched rate-1, bit index=0; in=1 -> IDLE, no err (glitch reject).
REQ-021 DATA sample: SHALL shift in into bit [index] of the shift register, LSB first; index<DATA_W-1 -> index+1, cnt=rate-1; index=DATA_W-1 -> STOP, cnt=rate-1.
REQ-022 STOP sample, in=1: SHALL on the next cycle show data=shift register, valid=1, done=1 for exactly one cycle, state IDLE.
REQ-023 STOP sample, in=0: SHALL pulse err for one cycle, leave data/valid unchanged, go IDLE.
REQ-024 A change of rate mid-frame SHALL NOT affect the frame in progress.
REQ-025 ack=1 SHALL clear valid and overrun next cycle; ack with valid=0 SHALL have no effect.
REQ-026 A good-frame capture with valid=1 and ack=0 in the same cycle SHALL set overrun and overwrite data.
REQ-027 A capture with ack=1 in the same cycle SHALL leave valid=1 and overrun unchanged (capture wins over ack for valid).
REQ-028 Sample cycles SHALL occur at fall cycle t + rate/2 (start), then every rate cycles after that.
REQ-029 Fall and IDLE re-entry in the same cycle: SHALL NOT start a frame until the state is IDLE on the cycle fall is seen.

Reset
REQ-030 nReset low SHALL immediately force state IDLE, cnt=0, index=0, shift register=0, data=0, valid=0, done=0, err=0, overrun=0, busy=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no done/err pulse; operation resumes on the first fall after release.

Verification
REQ-032 rate=16, frame 0xA5 with good stop, fall at cycle t -> START sample t+8, bit0 sample t+24, stop sample t+152; done=1, valid=1, data=0xA5 at t+153 only.
REQ-033 rate=16, in low for 3 cycles then high -> START sample sees 1, state back to IDLE, no done/err, busy low from t+9.
REQ-034 rate=16, byte 0x3C with stop bit driven 0 -> err pulse at t+153, data/valid retain previous values.
REQ-035 Two good frames 0x11 then 0x22 with no ack -> second done sets overrun=1, data=0x22; ack -> valid=0, overrun=0 next cycle.
REQ-036 nReset pulsed low at bit 4 of a frame -> all outputs 0 immediately, no done; next frame 0x5A received correctly.
REQ-037 rate=1 with fall pulses -> busy stays 0, no done/err; rate changed 16->8 mid-frame -> frame completes with 16-cycle bit periods.
